scan_sequencer: RTL and testbench

//   Upstream select generator for the 3-to-8 line decoder: drives the decoder's 3-bit

---
 rtl/scan_sequencer.sv | 138 +++++++++++++
 tb/tb_scan_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// scan_sequencer: select generator for a 3-to-8 line decoder.
// Steps sel through 0..LAST and holds each channel for (latched dwell + 1) cycles.
// Runs continuously (wrap-around) or as one sweep that ends with a done pulse.
// All outputs come straight from flops.
module scan_sequencer #(
  parameter int DWELL_W = 4,
  parameter int LAST    = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               oneshot,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               active,
  output logic               step,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0]         LAST_SEL = 3'(LAST);
  localparam logic [DWELL_W-1:0] CNT_ZERO = '0;
  localparam logic [DWELL_W-1:0] CNT_ONE  = DWELL_W'(1);

  state_t             state_q,  state_d;
  logic [DWELL_W-1:0] cnt_q,    cnt_d;
  logic [DWELL_W-1:0] dl_q,     dl_d;
  logic               mode_q,   mode_d;
  logic [2:0]         sel_q,    sel_d;
  logic               active_q, active_d;
  logic               step_q,   step_d;
  logic               done_q,   done_d;

  // Next-state and next-output logic; step and done default low so they pulse.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dl_d     = dl_q;
    mode_d   = mode_q;
    sel_d    = sel_q;
    active_d = active_q;
    step_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        sel_d    = 3'd0;
        active_d = 1'b0;
        // A coincident stop cancels the start request.
        if (start && !stop) begin
          state_d  = S_RUN;
          cnt_d    = CNT_ZERO;
          active_d = 1'b1;
          mode_d   = oneshot;
          dl_d     = dwell;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (stop) begin
          // Abort takes priority over any advance due on this edge.
          state_d  = S_IDLE;
          cnt_d    = CNT_ZERO;
          sel_d    = 3'd0;
          active_d = 1'b0;
        end else if (cnt_q != dl_q) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = CNT_ZERO;
          if (sel_q < LAST_SEL) begin
            sel_d  = sel_q + 3'd1;
            step_d = 1'b1;
          end else if (!mode_q) begin
            // Continuous mode wraps back to channel 0.
            sel_d  = 3'd0;
            step_d = 1'b1;
          end else begin
            // Single sweep finished: no step, one done pulse.
            state_d  = S_DONE;
            sel_d    = 3'd0;
            active_d = 1'b0;
            done_d   = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d  = S_IDLE;
        sel_d    = 3'd0;
        active_d = 1'b0;
      end

      default: begin
        state_d  = S_IDLE;
        cnt_d    = CNT_ZERO;
        sel_d    = 3'd0;
        active_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      dl_q     <= CNT_ZERO;
      mode_q   <= 1'b0;
      sel_q    <= 3'd0;
      active_q <= 1'b0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dl_q     <= dl_d;
      mode_q   <= mode_d;
      sel_q    <= sel_d;
      active_q <= active_d;
      step_q   <= step_d;
      done_q   <= done_d;
    end
  end

  assign sel    = sel_q;
  assign active = active_q;
  assign step   = step_q;
  assign done   = done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Testbench for scan_sequencer: directed stimulus pushes expected outputs into a
// queue; an independent monitor pops and compares them after each rising edge.
// Instance a uses LAST=7, instance b uses LAST=2.
module tb_scan_sequencer;

  logic       clk;
  logic       rst;
  logic       start_a, start_b;
  logic       stop_a, stop_b;
  logic       oneshot;
  logic [3:0] dwell;
  logic [2:0] sel_a, sel_b;
  logic       active_a, active_b;
  logic       step_a, step_b;
  logic       done_a, done_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         d;
    string      name;
    logic [2:0] sel;
    logic       active;
    logic       step;
    logic       done;
  } exp_t;

  exp_t exp_q[$];

  scan_sequencer #(.DWELL_W(4), .LAST(7)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .oneshot(oneshot),
    .dwell(dwell), .sel(sel_a), .active(active_a), .step(step_a), .done(done_a)
  );

  scan_sequencer #(.DWELL_W(4), .LAST(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .oneshot(oneshot),
    .dwell(dwell), .sel(sel_b), .active(active_b), .step(step_b), .done(done_b)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Queue the outputs expected from instance d after the next rising edge.
  task automatic push(input int d, input string nm, input logic [2:0] s,
                      input logic a, input logic st, input logic dn);
    exp_t e;
    e.d = d; e.name = nm; e.sel = s; e.active = a; e.step = st; e.done = dn;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int d, input string nm, input logic [2:0] s,
                     input logic a, input logic st, input logic dn);
    push(d, nm, s, a, st, dn);
    @(negedge clk);
  endtask

  // Monitor: after each rising edge, compare every queued expectation.
  initial begin : monitor
    exp_t e;
    logic [5:0] got;
    logic [5:0] want;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.d == 0) got = {sel_a, active_a, step_a, done_a};
        else          got = {sel_b, active_b, step_b, done_b};
        want = {e.sel, e.active, e.step, e.done};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL %s (dut %0d) t=%0t: got sel=%0d active=%0b step=%0b done=%0b, required sel=%0d active=%0b step=%0b done=%0b",
                   e.name, e.d, $time, got[5:3], got[2], got[1], got[0],
                   e.sel, e.active, e.step, e.done);
        end
      end
    end
  end

  // Directed stimulus.
  initial begin : stim
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; stop_a = 1'b0; stop_b = 1'b0;
    oneshot = 1'b0; dwell = 4'd0;
    @(negedge clk);
    push(0, "reset_a", 3'd0, 1'b0, 1'b0, 1'b0);
    cyc(1, "reset_b", 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Reset in the middle of a run at sel=5, then a cold restart (oneshot, dwell 0).
    start_a = 1'b1; oneshot = 1'b0; dwell = 4'd0;
    cyc(0, "t1_start", 3'd0, 1'b1, 1'b0, 1'b0);
    start_a = 1'b0;
    for (int k = 1; k <= 5; k++) cyc(0, $sformatf("t1_run_k%0d", k), 3'(k), 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    cyc(0, "t1_rst0", 3'd0, 1'b0, 1'b0, 1'b0);
    cyc(0, "t1_rst1", 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(0, "t1_idle", 3'd0, 1'b0, 1'b0, 1'b0);
    start_a = 1'b1; oneshot = 1'b1;
    cyc(0, "t1_cold_start", 3'd0, 1'b1, 1'b0, 1'b0);
    start_a = 1'b0; oneshot = 1'b0;
    for (int k = 1; k <= 7; k++) cyc(0, $sformatf("t1_cold_k%0d", k), 3'(k), 1'b1, 1'b1, 1'b0);
    cyc(0, "t1_cold_done", 3'd0, 1'b0, 1'b0, 1'b1);
    cyc(0, "t1_cold_after", 3'd0, 1'b0, 1'b0, 1'b0);

    // Continuous, dwell 0: new channel every cycle with wrap 7->0.
    start_a = 1'b1; oneshot = 1'b0; dwell = 4'd0;
    cyc(0, "t2_start", 3'd0, 1'b1, 1'b0, 1'b0);
    start_a = 1'b0;
    for (int k = 1; k <= 10; k++) cyc(0, $sformatf("t2_k%0d", k), 3'(k % 8), 1'b1, 1'b1, 1'b0);
    stop_a = 1'b1;
    cyc(0, "t2_stop", 3'd0, 1'b0, 1'b0, 1'b0);
    stop_a = 1'b0;

    // Oneshot, dwell 2: 3 cycles per channel, done at t0+24; inputs changed mid-run.
    start_a = 1'b1; oneshot = 1'b1; dwell = 4'd2;
    cyc(0, "t3_start", 3'd0, 1'b1, 1'b0, 1'b0);
    start_a = 1'b0; oneshot = 1'b0; dwell = 4'd0;
    for (int k = 1; k <= 23; k++)
      cyc(0, $sformatf("t3_k%0d", k), 3'(k / 3), 1'b1, (k % 3 == 0), 1'b0);
    cyc(0, "t3_done", 3'd0, 1'b0, 1'b0, 1'b1);
    start_a = 1'b1;  // ignored while in DONE
    cyc(0, "t3_after_done", 3'd0, 1'b0, 1'b0, 1'b0);
    start_a = 1'b0;
    cyc(0, "t3_idle", 3'd0, 1'b0, 1'b0, 1'b0);

    // Stop at sel=5 (coincides with an advance), then start+stop collision in IDLE.
    start_a = 1'b1; oneshot = 1'b0; dwell = 4'd0;
    cyc(0, "t4_start", 3'd0, 1'b1, 1'b0, 1'b0);
    start_a = 1'b0;
    for (int k = 1; k <= 5; k++) cyc(0, $sformatf("t4_k%0d", k), 3'(k), 1'b1, 1'b1, 1'b0);
    stop_a = 1'b1;
    cyc(0, "t4_stop", 3'd0, 1'b0, 1'b0, 1'b0);
    start_a = 1'b1;
    cyc(0, "t4_collide", 3'd0, 1'b0, 1'b0, 1'b0);
    start_a = 1'b0; stop_a = 1'b0;
    cyc(0, "t4_still_idle", 3'd0, 1'b0, 1'b0, 1'b0);

    // Dwell latched at 1; dwell=7 and a start pulse during RUN have no effect.
    start_a = 1'b1; oneshot = 1'b0; dwell = 4'd1;
    cyc(0, "t5_start", 3'd0, 1'b1, 1'b0, 1'b0);
    start_a = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      dwell = 4'd7;
      start_a = (k == 3 || k == 4);
      cyc(0, $sformatf("t5_k%0d", k), 3'((k / 2) % 8), 1'b1, (k % 2 == 0), 1'b0);
    end
    start_a = 1'b0; stop_a = 1'b1;
    cyc(0, "t5_stop", 3'd0, 1'b0, 1'b0, 1'b0);
    stop_a = 1'b0;

    // Maximum dwell (15): sel=0 held 16 cycles.
    start_a = 1'b1; oneshot = 1'b0; dwell = 4'd15;
    cyc(0, "tmax_start", 3'd0, 1'b1, 1'b0, 1'b0);
    start_a = 1'b0;
    for (int k = 1; k <= 16; k++)
      cyc(0, $sformatf("tmax_k%0d", k), 3'(k / 16), 1'b1, (k == 16), 1'b0);
    stop_a = 1'b1;
    cyc(0, "tmax_stop", 3'd0, 1'b0, 1'b0, 1'b0);
    stop_a = 1'b0;

    // LAST=2 instance: continuous dwell 1 -> 0,0,1,1,2,2,0,0,...
    start_b = 1'b1; oneshot = 1'b0; dwell = 4'd1;
    cyc(1, "t6_start", 3'd0, 1'b1, 1'b0, 1'b0);
    start_b = 1'b0;
    for (int k = 1; k <= 9; k++)
      cyc(1, $sformatf("t6_k%0d", k), 3'((k / 2) % 3), 1'b1, (k % 2 == 0), 1'b0);
    stop_b = 1'b1;
    cyc(1, "t6_stop", 3'd0, 1'b0, 1'b0, 1'b0);
    stop_b = 1'b0;

    // LAST=2 instance: oneshot dwell 0 -> done at t0+3.
    start_b = 1'b1; oneshot = 1'b1; dwell = 4'd0;
    cyc(1, "t6os_start", 3'd0, 1'b1, 1'b0, 1'b0);
    start_b = 1'b0; oneshot = 1'b0;
    for (int k = 1; k <= 2; k++) cyc(1, $sformatf("t6os_k%0d", k), 3'(k), 1'b1, 1'b1, 1'b0);
    cyc(1, "t6os_done", 3'd0, 1'b0, 1'b0, 1'b1);
    cyc(1, "t6os_after", 3'd0, 1'b0, 1'b0, 1'b0);

    // Drain: every queued expectation must have been consumed by the monitor.
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
